// File: rtl/cnt_mem_pkg.sv
// Shared definitions for the per-channel candidate memory bank:
// command encodings, FSM states and default geometry.
package cnt_mem_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_SUFFIX = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_e;

    localparam int unsigned N_CH_DEF   = 6;
    localparam int unsigned DEPTH_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 15;
    localparam int unsigned SUM_W_DEF  = 8;

endpackage

// File: rtl/cnt_mem_chan.sv
// One channel of the candidate memory: DEPTH x DATA_W rows with
// broadcast load, suffix overwrite, single-row clear and a
// combinational read mux (out-of-range rows read as zero).
// Build option: MIN_GATE_EN -- suffix writes a row only when the new
// sum field is strictly smaller than the stored one.
module cnt_mem_chan
    import cnt_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SUM_W  = SUM_W_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              suf_en,
    input  logic [AW-1:0]     suf_addr,
    input  logic [DATA_W-1:0] suf_data,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_row,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    if (DEPTH < 2 || SUM_W == 0 || SUM_W > DATA_W) begin : g_bad_geometry
        $error("cnt_mem_chan: invalid DEPTH/SUM_W/DATA_W combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  suf_wr;

    // Per-row suffix write decision: rows strictly above suf_addr
    always_comb begin
        suf_wr = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
`ifdef MIN_GATE_EN
            suf_wr[r] = suf_en && (AW'(r) > suf_addr) &&
                        (suf_data[DATA_W-1 -: SUM_W] < mem[r][DATA_W-1 -: SUM_W]);
`else
            suf_wr[r] = suf_en && (AW'(r) > suf_addr);
`endif
        end
    end

    // Row storage; commands are single-issue so the enables never overlap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (load_en)
                    mem[r] <= load_data;
                else if (suf_wr[r])
                    mem[r] <= suf_data;
                else if (clr_en && (clr_row == AW'(r)))
                    mem[r] <= '0;
            end
        end
    end

    // Read mux; addresses past the last row match nothing and return zero
    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (rd_addr == AW'(r)) rd_data = mem[r];
        end
    end

endmodule

// File: rtl/cnt_mem_bank.sv
// Candidate memory bank: N_CH channels sharing one command port.
// Holds the command handshake, the CLEAR sweep FSM and counter, and
// the registered write-done pulse.
// Build option: MIN_GATE_EN (applied inside each channel).
module cnt_mem_bank
    import cnt_mem_pkg::*;
#(
    parameter int unsigned N_CH   = N_CH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SUM_W  = SUM_W_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [N_CH-1:0]        cmd_mask,
    input  logic [DATA_W-1:0]      cmd_data,
    input  logic [N_CH*DATA_W-1:0] load_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [N_CH*DATA_W-1:0] rd_data,
    output logic                   busy,
    output logic                   wr_done
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_d;
    logic          fire;
    logic          load_en, suf_en, clr_en;

    assign busy      = (state_q == ST_CLR);
    assign cmd_ready = !busy;
    assign fire      = cmd_valid && cmd_ready;

    // State, sweep counter and done-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_done <= done_d;
        end
    end

    // Command decode and sweep sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load_en = 1'b0;
        suf_en  = 1'b0;
        clr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            load_en = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_SUFFIX: begin
                            suf_en = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLR;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLR: begin
                clr_en = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        cnt_mem_chan #(
            .DEPTH (DEPTH),
            .DATA_W(DATA_W),
            .SUM_W (SUM_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .load_en  (load_en && cmd_mask[i]),
            .load_data(load_data[i*DATA_W +: DATA_W]),
            .suf_en   (suf_en && cmd_mask[i]),
            .suf_addr (cmd_addr),
            .suf_data (cmd_data),
            .clr_en   (clr_en),
            .clr_row  (cnt_q),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_cnt_mem_bank.sv
// Self-checking bench for cnt_mem_bank: a behavioural memory model
// feeds an expected-value queue that is drained against DUT outputs.
module tb_cnt_mem_bank;
    import cnt_mem_pkg::*;

    localparam int unsigned N_CH   = 6;
    localparam int unsigned DEPTH  = 5;
    localparam int unsigned DATA_W = 15;
    localparam int unsigned SUM_W  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned W      = N_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [AW-1:0]     cmd_addr;
    logic [N_CH-1:0]   cmd_mask;
    logic [DATA_W-1:0] cmd_data;
    logic [W-1:0]      load_data;
    logic [AW-1:0]     rd_addr;
    logic [W-1:0]      rd_data;
    logic              busy;
    logic              wr_done;

    cnt_mem_bank #(
        .N_CH  (N_CH),
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_mask (cmd_mask),
        .cmd_data (cmd_data),
        .load_data(load_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .wr_done  (wr_done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] model [N_CH][DEPTH];
    int                tests = 0;
    int                fails = 0;
    string             tq[$];
    logic [W-1:0]      vq[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [W-1:0] v);
        tq.push_back(tag);
        vq.push_back(v);
    endtask

    task automatic sb_check(input logic [W-1:0] got);
        string        tag;
        logic [W-1:0] exp;
        check("sb_nonempty", W'(vq.size() != 0), W'(1));
        if (vq.size() != 0) begin
            tag = tq.pop_front();
            exp = vq.pop_front();
            check(tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_row(input int unsigned a);
        logic [W-1:0] r;
        r = '0;
        if (a < DEPTH)
            for (int unsigned i = 0; i < N_CH; i++) r[i*DATA_W +: DATA_W] = model[i][a];
        return r;
    endfunction

    task automatic model_zero();
        for (int unsigned i = 0; i < N_CH; i++)
            for (int unsigned r = 0; r < DEPTH; r++) model[i][r] = '0;
    endtask

    task automatic model_load(input logic [N_CH-1:0] m, input logic [W-1:0] ld);
        for (int unsigned i = 0; i < N_CH; i++)
            if (m[i])
                for (int unsigned r = 0; r < DEPTH; r++) model[i][r] = ld[i*DATA_W +: DATA_W];
    endtask

    task automatic model_suffix(input int unsigned a, input logic [N_CH-1:0] m,
                                input logic [DATA_W-1:0] d);
        for (int unsigned i = 0; i < N_CH; i++)
            if (m[i])
                for (int unsigned r = a + 1; r < DEPTH; r++) begin
`ifdef MIN_GATE_EN
                    if (d[DATA_W-1 -: SUM_W] < model[i][r][DATA_W-1 -: SUM_W]) model[i][r] = d;
`else
                    model[i][r] = d;
`endif
                end
    endtask

    // Reads every row plus two out-of-range addresses; only used while idle
    task automatic check_rows(input string tag);
        int unsigned addrs[7] = '{0, 1, 2, 3, 4, 5, 7};
        foreach (addrs[k]) begin
            rd_addr = AW'(addrs[k]);
            sb_push($sformatf("%s_row%0d", tag, addrs[k]), model_row(addrs[k]));
            #1;
            sb_check(rd_data);
        end
    endtask

    // Issues one LOAD/SUFFIX/NOP command and checks the done pulse
    task automatic do_cmd(input op_e op, input logic [AW-1:0] a, input logic [N_CH-1:0] m,
                          input logic [DATA_W-1:0] d, input logic [W-1:0] ld);
        logic exp_done;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_mask  = m;
        cmd_data  = d;
        load_data = ld;
        exp_done  = (op == OP_LOAD) || (op == OP_SUFFIX);
        @(posedge clk);
        if (op == OP_LOAD)   model_load(m, ld);
        if (op == OP_SUFFIX) model_suffix(int'(a), m, d);
        @(negedge clk);
        cmd_valid = 1'b0;
        sb_push($sformatf("wr_done_op%0d", op), W'(exp_done));
        sb_check(W'(wr_done));
        @(negedge clk);
        sb_push("wr_done_drop", W'(0));
        sb_check(W'(wr_done));
    endtask

    logic [W-1:0] ld1, ld2;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = '0;
        cmd_mask  = '0;
        cmd_data  = '0;
        load_data = '0;
        rd_addr   = '0;
        model_zero();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        sb_push("rst_ready", W'(1)); sb_check(W'(cmd_ready));
        sb_push("rst_busy",  W'(0)); sb_check(W'(busy));
        sb_push("rst_done",  W'(0)); sb_check(W'(wr_done));
        check_rows("rst");

        // LOAD all channels, channel i = i+1
        for (int unsigned i = 0; i < N_CH; i++) ld1[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        do_cmd(OP_LOAD, '0, '1, '0, ld1);
        check_rows("load");

        // Masked suffix overwrite rows 2..4 of channels 0 and 5
        do_cmd(OP_SUFFIX, 3'd1, 6'b100001, 15'h1234, '0);
        check_rows("suf1");

        // Boundary suffix addresses: nothing written, done still pulses
        do_cmd(OP_SUFFIX, 3'd4, '1, 15'h7abc, '0);
        check_rows("suf4");
        do_cmd(OP_SUFFIX, 3'd7, '1, 15'h7abc, '0);
        check_rows("suf7");

        // NOP: no effect, no done
        do_cmd(OP_NOP, 3'd0, '1, 15'h5555, '1);
        check_rows("nop");

        // Back-to-back suffix then load on consecutive edges
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SUFFIX; cmd_addr = 3'd3; cmd_mask = 6'b000110; cmd_data = 15'h0f0f;
        @(posedge clk);
        model_suffix(3, 6'b000110, 15'h0f0f);
        @(negedge clk);
        for (int unsigned i = 0; i < N_CH; i++) ld2[i*DATA_W +: DATA_W] = DATA_W'(16'h0100 + i);
        cmd_op = OP_LOAD; cmd_mask = 6'b001000; load_data = ld2;
        sb_push("b2b_done1", W'(1)); sb_check(W'(wr_done));
        @(posedge clk);
        model_load(6'b001000, ld2);
        @(negedge clk);
        cmd_valid = 1'b0;
        sb_push("b2b_done2", W'(1)); sb_check(W'(wr_done));
        @(negedge clk);
        check_rows("b2b");

        // CLEAR sweep with a LOAD held pending behind it
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_CLEAR; cmd_mask = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_op = OP_LOAD; cmd_mask = '1; load_data = ld1;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            sb_push($sformatf("clr_busy%0d", k), W'(1));  sb_check(W'(busy));
            sb_push($sformatf("clr_ready%0d", k), W'(0)); sb_check(W'(cmd_ready));
            rd_addr = 3'd2;
            sb_push($sformatf("clr_row2_c%0d", k), model_row(2));
            #1;
            sb_check(rd_data);
            @(posedge clk);
            for (int unsigned i = 0; i < N_CH; i++) model[i][k] = '0;
            @(negedge clk);
        end
        sb_push("clr_busy_end",  W'(0)); sb_check(W'(busy));
        sb_push("clr_ready_end", W'(1)); sb_check(W'(cmd_ready));
        sb_push("clr_done",      W'(1)); sb_check(W'(wr_done));
        sb_push("clr_all_zero",  W'(0)); sb_check(W'(model_row(0) | model_row(4)));
        @(posedge clk);
        model_load('1, ld1);
        @(negedge clk);
        cmd_valid = 1'b0;
        sb_push("held_load_done", W'(1)); sb_check(W'(wr_done));
        @(negedge clk);
        check_rows("held_load");

`ifdef MIN_GATE_EN
        // Strict less-than gate on the sum field
        for (int unsigned i = 0; i < N_CH; i++) ld2[i*DATA_W +: DATA_W] = {8'd50, 7'h11};
        do_cmd(OP_LOAD, '0, '1, '0, ld2);
        do_cmd(OP_SUFFIX, 3'd0, '1, {8'd60, 7'h22}, '0);
        check_rows("gate60");
        do_cmd(OP_SUFFIX, 3'd0, '1, {8'd50, 7'h33}, '0);
        check_rows("gate50");
        do_cmd(OP_SUFFIX, 3'd0, '1, {8'd40, 7'h44}, '0);
        check_rows("gate40");
`endif

        // Reset on the 3rd CLR cycle
        do_cmd(OP_LOAD, '0, '1, '0, ld1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_CLEAR;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        sb_push("mid_busy_before", W'(1)); sb_check(W'(busy));
        #1 reset = 1'b1;
        #1;
        model_zero();
        sb_push("mid_busy_async",  W'(0)); sb_check(W'(busy));
        sb_push("mid_ready_async", W'(1)); sb_check(W'(cmd_ready));
        #1 reset = 1'b0;
        @(negedge clk);
        sb_push("mid_done", W'(0)); sb_check(W'(wr_done));
        check_rows("mid_rst");
        repeat (DEPTH + 1) @(negedge clk);
        sb_push("mid_idle", W'(0)); sb_check(W'(busy));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
